// File: rtl/shading_pipe_if.sv
// Stream-side signals of the Lambert shading pipeline: pixel-in handshake with
// vectors and sideband, pixel-out handshake with packed RGB and sideband.
interface shading_pipe_if #(
  parameter int DATA_WIDTH = 32,
  parameter int CH_BITS    = 8
);
  logic                         s_valid;
  logic                         s_ready;
  logic                         s_hit;
  logic [1:0]                   s_user;
  logic signed [DATA_WIDTH-1:0] nx, ny, nz;
  logic signed [DATA_WIDTH-1:0] lx, ly, lz;
  logic                         m_valid;
  logic                         m_ready;
  logic [3*CH_BITS-1:0]         m_rgb;
  logic [1:0]                   m_user;

  // Environment view: feeds pixels in, accepts pixels out.
  modport master (
    output s_valid, s_hit, s_user, nx, ny, nz, lx, ly, lz, m_ready,
    input  s_ready, m_valid, m_rgb, m_user
  );

  // Shader view.
  modport slave (
    input  s_valid, s_hit, s_user, nx, ny, nz, lx, ly, lz, m_ready,
    output s_ready, m_valid, m_rgb, m_user
  );
endinterface

// File: rtl/shading_pipe.sv
// Four-stage ambient + Lambert diffuse shader with valid/ready backpressure.
// S1: component products, S2: dot product and ambient term,
// S3: per-channel coefficient scaling, S4: sum, clamp and output register.
// The whole pipe freezes while the output pixel is offered but not taken.
module shading_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int FRAC_BITS  = 24,
  parameter int COEF_WIDTH = 16,
  parameter int CH_BITS    = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  shading_pipe_if.slave           bus,
  input  logic [3*COEF_WIDTH-1:0] amb_coef,
  input  logic [3*COEF_WIDTH-1:0] diff_coef,
  input  logic [3*CH_BITS-1:0]    bg_color,
  output logic                    idle
);
  localparam int PROD_W = 2 * DATA_WIDTH;
  localparam int DOT_W  = 2 * DATA_WIDTH + 2;
  localparam int SCL_W  = DATA_WIDTH + COEF_WIDTH;
  localparam int SUM_W  = SCL_W + 1;

  // Largest positive DATA_WIDTH value, held at dot-product width for comparison.
  localparam logic signed [DOT_W-1:0] DIFF_MAX =
    {{(DOT_W - DATA_WIDTH + 1){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] HALF = DATA_WIDTH'(1) << (FRAC_BITS - 1);
  localparam logic [SUM_W-1:0]      ONE  = SUM_W'(1) << FRAC_BITS;

  logic stall;
  logic v1, v2, v3;

  // S1 registers
  logic signed [PROD_W-1:0]     px1, py1, pz1;
  logic signed [DATA_WIDTH-1:0] ny1;
  logic                         hit1;
  logic [1:0]                   user1;

  // S2 registers
  logic [DATA_WIDTH-1:0] amb2, diff2;
  logic                  hit2;
  logic [1:0]            user2;

  // S3 registers
  logic [SCL_W-1:0] amb_sc3  [3];
  logic [SCL_W-1:0] diff_sc3 [3];
  logic             hit3;
  logic [1:0]       user3;

  // Combinational stage results
  logic signed [DOT_W-1:0] dot, dot_sh;
  logic [DATA_WIDTH-1:0]   ny_pos, amb_next, diff_next;
  logic [SUM_W-1:0]        shade;
  logic [3*CH_BITS-1:0]    rgb_next;

  assign stall       = bus.m_valid & ~bus.m_ready;
  assign bus.s_ready = rst | ~stall;
  assign idle        = ~(v1 | v2 | v3 | bus.m_valid);

  // Valid bits and output register: cleared by reset, advance only when not stalled.
  // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1          <= 1'b0;
      v2          <= 1'b0;
      v3          <= 1'b0;
      bus.m_valid <= 1'b0;
      bus.m_rgb   <= '0;
      bus.m_user  <= '0;
    end else if (!stall) begin
      v1          <= bus.s_valid;
      v2          <= v1;
      v3          <= v2;
      bus.m_valid <= v3;
      if (v3) begin
        bus.m_rgb  <= rgb_next;
        bus.m_user <= user3;
      end
    end
  end

  // Datapath registers for S1..S3, frozen together with the valid bits on a stall.
  // NOTE: no reset here; these contents are only ever consumed behind a valid bit.
  always_ff @(posedge clk) begin
    if (!stall) begin
      px1   <= PROD_W'(bus.nx) * PROD_W'(bus.lx);
      py1   <= PROD_W'(bus.ny) * PROD_W'(bus.ly);
      pz1   <= PROD_W'(bus.nz) * PROD_W'(bus.lz);
      ny1   <= bus.ny;
      hit1  <= bus.s_hit;
      user1 <= bus.s_user;

      amb2  <= amb_next;
      diff2 <= diff_next;
      hit2  <= hit1;
      user2 <= user1;

      for (int c = 0; c < 3; c++) begin
        amb_sc3[c]  <= SCL_W'(amb2)  * SCL_W'(amb_coef[c*COEF_WIDTH +: COEF_WIDTH]);
        diff_sc3[c] <= SCL_W'(diff2) * SCL_W'(diff_coef[c*COEF_WIDTH +: COEF_WIDTH]);
      end
      hit3  <= hit2;
      user3 <= user2;
    end
  end

  // S2: full-precision dot product clamped to [0, max], ambient = 0.5 + 0.5*max(ny,0).
  // NOTE: every branch assigns every output so no latch is inferred.
  always_comb begin
    dot    = DOT_W'(px1) + DOT_W'(py1) + DOT_W'(pz1);
    dot_sh = dot >>> FRAC_BITS;
    if (dot_sh[DOT_W-1]) begin
      diff_next = '0;
    end else if (dot_sh > DIFF_MAX) begin
      diff_next = DIFF_MAX[DATA_WIDTH-1:0];
    end else begin
      diff_next = dot_sh[DATA_WIDTH-1:0];
    end
    ny_pos   = ny1[DATA_WIDTH-1] ? '0 : ny1;
    amb_next = HALF + (ny_pos >> 1);
  end

  // S4: per-channel sum, rescale, saturate at 1.0 and truncate; misses take bg_color.
  always_comb begin
    rgb_next = bg_color;
    shade    = '0;
    for (int c = 0; c < 3; c++) begin
      shade = (SUM_W'(amb_sc3[c]) + SUM_W'(diff_sc3[c])) >> (COEF_WIDTH - 1);
      if (hit3) begin
        rgb_next[c*CH_BITS +: CH_BITS] =
          (shade >= ONE) ? {CH_BITS{1'b1}} : shade[FRAC_BITS-1 -: CH_BITS];
      end
    end
  end
endmodule

// File: doc/shading_pipe.md
Name: shading_pipe

Overview:
- Pipelined, parametrised successor to the combinational Lambert shader in the ray marcher.
- Takes a surface normal, a light vector and a hit flag per pixel; returns a packed RGB pixel (ambient + diffuse).
- Adds a valid/ready handshake with backpressure, runtime colour coefficients, a background colour for misses, and a user/last sideband pass-through.
- Sits between the march/normal-estimation stage and the video output stream.

Parameters:
- DATA_WIDTH, 32, width of signed fixed-point vector components.
- FRAC_BITS, 24, fractional bits of vector components (default Q8.24).
- COEF_WIDTH, 16, width of unsigned Q0.(COEF_WIDTH-1) colour coefficients.
- CH_BITS, 8, bits per output colour channel.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- s_valid  in  1  input pixel valid.
- s_ready  out  1  block can accept an input pixel.
- s_hit  in  1  1 = surface hit, 0 = miss (use background colour).
- s_user  in  2  sideband {eol, sof}, passed through unchanged.
- nx, ny, nz  in  DATA_WIDTH each  signed normal components.
- lx, ly, lz  in  DATA_WIDTH each  signed light-vector components.
- amb_coef  in  3*COEF_WIDTH  {R,G,B} ambient coefficients; quasi-static.
- diff_coef  in  3*COEF_WIDTH  {R,G,B} diffuse coefficients; quasi-static.
- bg_color  in  3*CH_BITS  {R,G,B} colour emitted on miss; quasi-static.
- m_valid  out  1  output pixel valid.
- m_ready  in  1  downstream accepts the output pixel.
- m_rgb  out  3*CH_BITS  {R,G,B} output pixel.
- m_user  out  2  sideband aligned with m_rgb.
- idle  out  1  no valid data held in any stage.

Behaviour:
- Four-stage pipeline: S1 products, S2 dot/ambient, S3 per-channel coefficient scaling, S4 sum/clamp/output register.
- Latency: an input accepted in cycle t appears on m_rgb with m_valid=1 in cycle t+4 when there is no stall.
- Throughput: 1 pixel per cycle.
- Each stage has a valid bit. Bubbles propagate as invalid.
- Stall condition: stall = m_valid & ~m_ready. On stall, all stages hold.
- s_ready = ~stall. A transfer occurs when s_valid & s_ready; likewise m_valid & m_ready.
- m_rgb and m_user stay stable while m_valid=1 and m_ready=0.
- Reset: all stage valid bits = 0, m_valid = 0, m_rgb = 0, m_user = 0, idle = 1.
  - s_ready = 1 during and after reset.
  - Reset mid-operation discards all in-flight pixels; no partial output is emitted.
- Dot product:
  - dot = nx*lx + ny*ly + nz*lz, computed at full precision (2*DATA_WIDTH+2 bits, signed), then arithmetic shift right by FRAC_BITS.
  - diffuse = 0 if dot < 0.
  - Otherwise diffuse = dot, saturated to the maximum positive DATA_WIDTH value.
- Ambient: ambient = 0.5 + 0.5*max(ny, 0), in the input Q format.
- Channel c value: shade_c = (ambient*amb_c + diffuse*diff_c) >> (COEF_WIDTH-1). Products are unsigned with no intermediate truncation.
- Clamp to output:
  - shade_c ≥ 1.0 (i.e. ≥ 2^FRAC_BITS) → all ones.
  - Otherwise → bits [FRAC_BITS-1 : FRAC_BITS-CH_BITS] (truncate, no rounding). shade_c is never negative by construction.
- Miss: s_hit = 0 → m_rgb = bg_color, with the same latency. Vector inputs are ignored.
- s_user travels with its pixel through every stage.
- Coefficients and bg_color may change only while idle = 1; results are undefined otherwise.
- idle = ~(any stage valid).

Test Plan:
- Reset, default coefficients (amb 6553/9830/13107, diff 26214/22937/16384), hit.
  - n = (0, 0x01000000, 0), l = (0, 0x01000000, 0) → m_rgb = 0xFFFFE6, exactly 4 cycles after acceptance.
- Same n, l = (0, 0xFF000000, 0) → diffuse clamped to 0 → m_rgb = 0x334C66.
- n = (0x01000000, 0, 0), l = (0, 0x01000000, 0) → ambient 0.5, diffuse 0 → m_rgb = 0x192633.
- s_hit = 0, bg_color = 0x102030, arbitrary vectors → m_rgb = 0x102030, m_user equal to the input's s_user.
- Stream of 8 pixels with m_ready low for 3 cycles mid-stream:
  - s_ready drops in the same cycles; m_rgb is held.
  - All 8 pixels emerge in order, with no loss or duplication.
- Assert rst with 3 pixels in flight → the next cycle shows m_valid = 0 and idle = 1; no stale pixel ever appears on the output.
